// File: rtl/nios_key_pio_irq.sv
// Debounced key PIO with edge capture and a level interrupt, Avalon-MM slave.
// Keys are synchronized, debounced per bit, edge-detected into sticky capture bits.
module nios_key_pio_irq #(
    parameter int WIDTH           = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int EDGE_TYPE       = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_level;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_d;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] clr_mask;
    logic             wr_en;
    logic             unused_wdata;

    assign unused_wdata = ^writedata;
    assign wr_en        = chipselect & ~write_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign sync_level = sync_q[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign stable = sync_level;
        end else begin : g_debounce
            localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

            for (genvar b = 0; b < WIDTH; b++) begin : g_bit
                logic [CW-1:0] cnt;
                logic          stable_bit;

                // The count holds the number of consecutive differing samples seen so far.
                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) begin
                        cnt        <= '0;
                        stable_bit <= 1'b0;
                    end else if (sync_level[b] == stable_bit) begin
                        cnt <= '0;
                    end else if (cnt == CNT_LAST) begin
                        cnt        <= '0;
                        stable_bit <= sync_level[b];
                    end else if (cnt != '1) begin
                        cnt <= cnt + CW'(1);
                    end
                end

                assign stable[b] = stable_bit;
            end
        end
    endgenerate

    always_comb begin
        edge_hit = stable ^ stable_d;
        if (EDGE_TYPE == 0)      edge_hit = stable & ~stable_d;
        else if (EDGE_TYPE == 1) edge_hit = ~stable & stable_d;
    end

    assign clr_mask = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

    // A new edge in the same cycle as its clear keeps the bit set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable_d <= '0;
            edge_cap <= '0;
            irq_mask <= '0;
        end else begin
            stable_d <= stable;
            edge_cap <= (edge_cap & ~clr_mask) | edge_hit;
            if (wr_en && address == 2'd2) irq_mask <= writedata[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            case (address)
                2'd0:    readdata <= 32'(stable);
                2'd2:    readdata <= 32'(irq_mask);
                2'd3:    readdata <= 32'(edge_cap);
                default: readdata <= '0;
            endcase
        end
    end

    assign irq = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_nios_key_pio_irq.sv
// Bench for nios_key_pio_irq: register-map vector table, hand sequences for the
// debounce/capture corner cases, and a randomized run against a history-based model.
module tb_nios_key_pio_irq;

    localparam int DB = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic [31:0] readdata;
    logic        irq;

    logic [1:0]  w_address;
    logic        w_chipselect;
    logic        w_write_n;
    logic [31:0] w_writedata;
    logic [31:0] w_in_port;
    logic [31:0] w_readdata;
    logic        w_irq;

    always #5 clk = ~clk;

    nios_key_pio_irq u_dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(readdata), .irq(irq)
    );

    nios_key_pio_irq #(.WIDTH(32), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(2)) u_wide (
        .clk(clk), .reset_n(reset_n), .address(w_address), .chipselect(w_chipselect),
        .write_n(w_write_n), .writedata(w_writedata), .in_port(w_in_port),
        .readdata(w_readdata), .irq(w_irq)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: a key level is accepted once the last DB synchronized
    // samples all disagree with the currently accepted level.
    logic [3:0]  m_sync0, m_sync1, m_stable, m_prev, m_cap, m_mask;
    logic [31:0] m_rd;
    logic [3:0]  m_hist[$];

    task automatic model_reset();
        m_sync0 = '0; m_sync1 = '0; m_stable = '0; m_prev = '0;
        m_cap = '0; m_mask = '0; m_rd = '0;
        m_hist.delete();
    endtask

    task automatic model_step();
        logic [3:0] lvl, nstable, clr;
        bit         diff_run;
        lvl = m_sync1;
        m_hist.push_back(lvl);
        if (m_hist.size() > DB) void'(m_hist.pop_front());
        nstable = m_stable;
        for (int b = 0; b < 4; b++) begin
            if (m_hist.size() == DB) begin
                diff_run = 1'b1;
                foreach (m_hist[i]) if (m_hist[i][b] == m_stable[b]) diff_run = 1'b0;
                if (diff_run) nstable[b] = lvl[b];
            end
        end
        clr = (chipselect && !write_n && address == 2'd3) ? writedata[3:0] : 4'h0;
        case (address)
            2'd0:    m_rd = {28'h0, m_stable};
            2'd2:    m_rd = {28'h0, m_mask};
            2'd3:    m_rd = {28'h0, m_cap};
            default: m_rd = 32'h0;
        endcase
        m_cap = (m_cap & ~clr) | (~m_stable & m_prev);
        if (chipselect && !write_n && address == 2'd2) m_mask = writedata[3:0];
        m_prev   = m_stable;
        m_stable = nstable;
        m_sync1  = m_sync0;
        m_sync0  = in_port;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset_n) model_reset();
        else          model_step();
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
        tick();
        chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
        address = a;
        tick();
        check(name, readdata, exp);
    endtask

    typedef struct {
        logic [1:0]  addr;
        logic        cs;
        logic        wr_n;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t vt[14];

    initial begin
        vt[0]  = '{2'd2, 1'b1, 1'b0, 32'h0000_000A, 32'h0, 1'b0};
        vt[1]  = '{2'd2, 1'b0, 1'b0, 32'h0,         32'hA, 1'b0};
        vt[2]  = '{2'd2, 1'b1, 1'b1, 32'h0000_0005, 32'hA, 1'b0};
        vt[3]  = '{2'd2, 1'b0, 1'b0, 32'h0000_0005, 32'hA, 1'b0};
        vt[4]  = '{2'd0, 1'b1, 1'b0, 32'h0,         32'hF, 1'b0};
        vt[5]  = '{2'd0, 1'b0, 1'b1, 32'h0,         32'hF, 1'b0};
        vt[6]  = '{2'd1, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b0};
        vt[7]  = '{2'd1, 1'b0, 1'b1, 32'h0,         32'h0, 1'b0};
        vt[8]  = '{2'd3, 1'b1, 1'b0, 32'h0000_000F, 32'h0, 1'b0};
        vt[9]  = '{2'd2, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hA, 1'b0};
        vt[10] = '{2'd2, 1'b0, 1'b1, 32'h0,         32'hF, 1'b0};
        vt[11] = '{2'd3, 1'b0, 1'b1, 32'h0,         32'h0, 1'b0};
        vt[12] = '{2'd2, 1'b1, 1'b0, 32'h0,         32'hF, 1'b0};
        vt[13] = '{2'd2, 1'b0, 1'b1, 32'h0,         32'h0, 1'b0};

        reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
        in_port = 4'hF;
        w_address = '0; w_chipselect = 1'b0; w_write_n = 1'b1; w_writedata = '0; w_in_port = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_readdata", readdata, 32'h0);
        check("reset_irq", {31'h0, irq}, 32'h0);
        check("reset_wide_readdata", w_readdata, 32'h0);
        reset_n = 1'b1;

        // Key held high through reset release is accepted after sync + debounce.
        repeat (18) tick();
        check("release_data_hold", readdata, 32'h0);
        tick();
        check("release_data_accept", readdata, 32'hF);
        repeat (21) tick();
        rd(2'd3, 32'h0, "rise_not_captured");

        // Wide instance: no debounce, any edge.
        w_address = 2'd3; w_in_port = 32'h8000_0000;
        repeat (3) tick();
        check("wide_cap_latency", w_readdata, 32'h0);
        tick();
        check("wide_cap_rise", w_readdata, 32'h8000_0000);
        w_chipselect = 1'b1; w_write_n = 1'b0; w_writedata = 32'hFFFF_FFFF;
        tick();
        w_chipselect = 1'b0; w_write_n = 1'b1; w_writedata = '0;
        tick();
        check("wide_cap_clear", w_readdata, 32'h0);
        w_in_port = 32'h0;
        repeat (4) tick();
        check("wide_cap_fall", w_readdata, 32'h8000_0000);
        check("wide_irq_masked", {31'h0, w_irq}, 32'h0);
        w_address = 2'd1;
        tick();
        check("wide_reserved", w_readdata, 32'h0);

        for (int i = 0; i < 14; i++) begin
            address = vt[i].addr; chipselect = vt[i].cs;
            write_n = vt[i].wr_n; writedata = vt[i].wdata;
            tick();
            check($sformatf("vec%0d_readdata", i), readdata, vt[i].exp_rd);
            check($sformatf("vec%0d_irq", i), {31'h0, irq}, {31'h0, vt[i].exp_irq});
        end
        chipselect = 1'b0; write_n = 1'b1; writedata = '0;

        // Falling edge on bit 0 with mask clear.
        address = 2'd0; in_port = 4'hE;
        repeat (18) tick();
        check("fall_data_hold", readdata, 32'hF);
        tick();
        check("fall_data_accept", readdata, 32'hE);
        address = 2'd3;
        tick();
        check("fall_cap", readdata, 32'h1);
        check("fall_irq_masked", {31'h0, irq}, 32'h0);
        repeat (10) tick();

        // Masked interrupt and write-1-to-clear.
        wr(2'd3, 32'h1);
        rd(2'd3, 32'h0, "cap_w1c");
        in_port = 4'hF;
        repeat (25) tick();
        wr(2'd2, 32'h1);
        check("irq_idle", {31'h0, irq}, 32'h0);
        in_port = 4'hE;
        repeat (18) tick();
        check("irq_before_edge", {31'h0, irq}, 32'h0);
        tick();
        check("irq_on_edge", {31'h0, irq}, 32'h1);
        wr(2'd3, 32'h1);
        check("irq_cleared", {31'h0, irq}, 32'h0);
        rd(2'd3, 32'h0, "cap_after_clear");

        // Short glitch on bit 1 is rejected.
        in_port = 4'hC;
        repeat (10) tick();
        in_port = 4'hE;
        repeat (30) tick();
        rd(2'd0, 32'hE, "glitch_data");
        rd(2'd3, 32'h0, "glitch_cap");

        // Clear and new edge on bit 2 in the same cycle.
        in_port = 4'hF;
        repeat (25) tick();
        in_port = 4'hA;
        repeat (19) tick();
        rd(2'd3, 32'h5, "cap_bits_0_2");
        in_port = 4'hE;
        repeat (25) tick();
        in_port = 4'hA;
        repeat (18) tick();
        wr(2'd3, 32'h4);
        rd(2'd3, 32'h5, "edge_wins_clear");
        wr(2'd3, 32'h4);
        rd(2'd3, 32'h1, "clear_bit2_only");

        // Async reset with everything captured and unmasked.
        wr(2'd2, 32'hF);
        in_port = 4'hF;
        repeat (25) tick();
        in_port = 4'h0;
        repeat (20) tick();
        rd(2'd3, 32'hF, "cap_all");
        check("irq_all", {31'h0, irq}, 32'h1);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("irq_async_reset", {31'h0, irq}, 32'h0);
        check("readdata_async_reset", readdata, 32'h0);
        repeat (3) tick();
        reset_n = 1'b1;
        rd(2'd2, 32'h0, "mask_after_reset");
        rd(2'd3, 32'h0, "cap_after_reset");
        rd(2'd0, 32'h0, "data_after_reset");
        rd(2'd1, 32'h0, "reserved_after_reset");
        check("irq_after_reset", {31'h0, irq}, 32'h0);

        // Randomized traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(39) == 0) in_port = 4'($urandom);
            address    = 2'($urandom);
            chipselect = 1'($urandom_range(1));
            write_n    = ($urandom_range(3) != 0);
            writedata  = $urandom;
            tick();
            check("rand_readdata", readdata, m_rd);
            check("rand_irq", {31'h0, irq}, {31'h0, |(m_cap & m_mask)});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nios_key_pio_irq.md
NIOS_KEY_PIO_IRQ -- requirements
Module: nios_key_pio_irq

Interface
REQ-001 Parameter WIDTH, default 4, number of key input bits; legal range 1..32.
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer flops per bit; legal range 2..4.
REQ-003 Parameter DEBOUNCE_CYCLES, default 16, consecutive stable cycles needed to accept a new level; 0 = debounce bypassed; legal range 0..65535.
REQ-004 Parameter EDGE_TYPE, default 1, edge that sets capture: 0 = rising, 1 = falling, 2 = any.
REQ-005 clk  input  1  system clock; all state on rising edge.
REQ-006 reset_n  input  1  reset, asynchronous, active-low.
REQ-007 address  input  2  Avalon-MM slave word address.
REQ-008 chipselect  input  1  slave select; qualifies write_n.
REQ-009 write_n  input  1  active-low write strobe.
REQ-010 writedata  input  32  write data.
REQ-011 in_port  input  WIDTH  asynchronous key inputs.
REQ-012 readdata  output  32  registered read data.
REQ-013 irq  output  1  level interrupt request, active-high.

Function
REQ-014 Register map: 0 = DATA (RO, debounced level), 1 = reserved (reads 0, writes ignored), 2 = IRQ_MASK (RW), 3 = EDGE_CAP (read; write-1-to-clear).
REQ-015 Each in_port bit shall pass through SYNC_STAGES flops before any other use; no other logic touches raw in_port.
REQ-016 Per bit, debounce: stable level updates to synchronized level only after synchronized level differs from stable level for DEBOUNCE_CYCLES consecutive cycles; any return to stable level restarts the count at 0.
REQ-017 Debounce counter width shall be ceil(log2(DEBOUNCE_CYCLES+1)); counter saturates, never wraps.
REQ-018 DEBOUNCE_CYCLES = 0: stable level equals synchronized level, no counter logic.
REQ-019 Edge detect compares stable level with its one-cycle-delayed copy; qualifying edge per EDGE_TYPE sets corresponding EDGE_CAP bit one cycle after stable level changes.
REQ-020 EDGE_CAP bits are sticky until cleared by a write to address 3 with the bit's writedata bit = 1; writedata 0 bits leave capture unchanged.
REQ-021 Same-cycle new edge and clear on one bit: bit remains 1 (edge wins).
REQ-022 Write to address 2 (chipselect=1, write_n=0) loads IRQ_MASK[WIDTH-1:0] from writedata; takes effect next cycle.
REQ-023 irq = OR over bits of (EDGE_CAP & IRQ_MASK), combinational from registered state, no extra latency.
REQ-024 Reads: readdata updated every clock from address regardless of chipselect; one-cycle read latency; bits [31:WIDTH] always 0.
REQ-025 Writes to addresses 0 and 1 have no effect.

Reset
REQ-026 reset_n low asynchronously clears: synchronizer flops, stable levels, delayed copies, debounce counters, EDGE_CAP, IRQ_MASK, readdata; irq = 0.
REQ-027 Stable level resets to 0; a key held high through reset release is accepted DEBOUNCE_CYCLES + SYNC_STAGES cycles later and may produce a rising edge.
REQ-028 Reset asserted mid-debounce or mid-read discards in-progress state; no capture survives reset.

Verification
REQ-029 Defaults; in_port[0] 1->0 held 30 cycles -> DATA[0]=0 after 2+16 cycles, EDGE_CAP=0x1 next cycle, irq stays 0 (mask 0).
REQ-030 Write IRQ_MASK=0x1, then falling edge on bit 0 -> irq=1; write 0x1 to address 3 -> EDGE_CAP=0, irq=0 next cycle.
REQ-031 Glitch: bit 1 toggles low for 10 cycles then high -> DATA[1] unchanged, EDGE_CAP[1]=0.
REQ-032 Bits 0 and 2 captured, write 0x4 to address 3 same cycle as new edge on bit 2 -> EDGE_CAP=0x5 (bit 0 kept, bit 2 edge wins).
REQ-033 WIDTH=32, DEBOUNCE_CYCLES=0, EDGE_TYPE=2: toggle bit 31 -> EDGE_CAP=0x80000000 after each toggle; read address 1 -> 0.
REQ-034 reset_n pulsed low with EDGE_CAP=0xF, IRQ_MASK=0xF -> irq=0 immediately, all registers read 0 after release.
